// File: rtl/rcu_pll_seq.sv
// rcu_pll_seq: PLL enable/lock/stability sequencer driving glitch-free clock dividers.
// Define RCU_PLL_TIMEOUT_EN to build the lock-acquire timeout.
module rcu_pll_seq #(
    parameter int CHNL_NUM       = 4,
    parameter int DIV_WIDTH      = 8,
    parameter int LOCK_CNT_WIDTH = 16,
    parameter logic [LOCK_CNT_WIDTH-1:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          pll_en_i,
    input  logic [LOCK_CNT_WIDTH-1:0]     lock_wait_i,
    input  logic                          pll_lock_i,
    input  logic [CHNL_NUM*DIV_WIDTH-1:0] div_val_i,
    input  logic                          div_upd_i,
    output logic                          div_upd_ack_o,
    output logic                          div_busy_o,
    output logic                          pll_en_o,
    output logic                          pll_sel_o,
    output logic [1:0]                    state_o,
    output logic                          lock_lost_o,
    input  logic                          lock_lost_clr_i,
    output logic                          timeout_o,
    output logic [CHNL_NUM-1:0]           clk_en_o,
    output logic [CHNL_NUM-1:0]           div_clk_o
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ACQ  = 2'd1,
        S_STAB = 2'd2,
        S_RUN  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic                      lock_m_q, lock_s_q;
    logic [LOCK_CNT_WIDTH-1:0] stab_q, stab_d;
    logic                      lost_q, lost_d;
    logic                      lost_set;

`ifdef RCU_PLL_TIMEOUT_EN
    logic [LOCK_CNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                      blk_q, blk_d;
    logic                      tmo_q, tmo_d;
`endif

    // FSM next state
    always_comb begin
        state_d  = state_q;
        stab_d   = '0;
        lost_set = 1'b0;
`ifdef RCU_PLL_TIMEOUT_EN
        tcnt_d   = '0;
        blk_d    = blk_q & pll_en_i;
        tmo_d    = tmo_q;
`endif
        if (!pll_en_i) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF: begin
`ifdef RCU_PLL_TIMEOUT_EN
                    if (!blk_q) begin
                        state_d = S_ACQ;
                        tmo_d   = 1'b0;
                    end
`else
                    state_d = S_ACQ;
`endif
                end
                S_ACQ: begin
                    if (lock_s_q) begin
                        state_d = S_STAB;
`ifdef RCU_PLL_TIMEOUT_EN
                    end else if (tcnt_q == TIMEOUT_CYC - LOCK_CNT_WIDTH'(1)) begin
                        state_d = S_OFF;
                        tmo_d   = 1'b1;
                        blk_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + LOCK_CNT_WIDTH'(1);
`endif
                    end
                end
                S_STAB: begin
                    if (!lock_s_q) begin
                        state_d = S_ACQ;
                    end else if (stab_q == lock_wait_i) begin
                        state_d = S_RUN;
                    end else begin
                        stab_d = stab_q + LOCK_CNT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d  = S_ACQ;
                        lost_set = 1'b1;
                    end
                end
            endcase
        end
        // a fresh loss wins over a simultaneous clear
        if (lost_set) begin
            lost_d = 1'b1;
        end else if (lock_lost_clr_i) begin
            lost_d = 1'b0;
        end else begin
            lost_d = lost_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_OFF;
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
            stab_q   <= '0;
            lost_q   <= 1'b0;
`ifdef RCU_PLL_TIMEOUT_EN
            tcnt_q   <= '0;
            blk_q    <= 1'b0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lock_m_q <= pll_lock_i;
            lock_s_q <= lock_m_q;
            stab_q   <= stab_d;
            lost_q   <= lost_d;
`ifdef RCU_PLL_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            blk_q    <= blk_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

`ifdef RCU_PLL_TIMEOUT_EN
    assign timeout_o = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign timeout_o  = 1'b0;
`endif

    logic [DIV_WIDTH-1:0] sh_q   [CHNL_NUM];
    logic [DIV_WIDTH-1:0] sh_d   [CHNL_NUM];
    logic [DIV_WIDTH-1:0] pend_q [CHNL_NUM];
    logic [DIV_WIDTH-1:0] pend_d [CHNL_NUM];
    logic [DIV_WIDTH-1:0] cnt_q  [CHNL_NUM];
    logic [DIV_WIDTH-1:0] cnt_d  [CHNL_NUM];
    logic [CHNL_NUM-1:0]  pv_q, pv_d;
    logic [CHNL_NUM-1:0]  ce_q, ce_d;
    logic [CHNL_NUM-1:0]  dc_q, dc_d;
    logic [CHNL_NUM-1:0]  d_le1, wrap;
    logic                 busy_q, busy_d;
    logic                 ack_q, ack_d;
    logic                 run_q, act;

    assign run_q = (state_q == S_RUN);
    assign act   = run_q && (state_d == S_RUN);

    for (genvar k = 0; k < CHNL_NUM; k++) begin : g_ch
        assign d_le1[k] = (sh_q[k] <= DIV_WIDTH'(1));
        assign wrap[k]  = !d_le1[k] && (cnt_q[k] == sh_q[k] - DIV_WIDTH'(1));
    end

    // a channel swaps shadow only at its own period boundary
    always_comb begin
        busy_d = busy_q;
        ack_d  = 1'b0;
        pv_d   = pv_q;
        ce_d   = '0;
        dc_d   = '0;
        for (int k = 0; k < CHNL_NUM; k++) begin
            sh_d[k]   = sh_q[k];
            pend_d[k] = pend_q[k];
            cnt_d[k]  = '0;
            if (act) begin
                ce_d[k] = d_le1[k] | wrap[k];
                dc_d[k] = !d_le1[k] && (cnt_q[k] < (sh_q[k] >> 1));
                if (!d_le1[k] && !wrap[k]) begin
                    cnt_d[k] = cnt_q[k] + DIV_WIDTH'(1);
                end
            end
            if (pv_q[k] && (!run_q || d_le1[k] || wrap[k])) begin
                sh_d[k]  = pend_q[k];
                cnt_d[k] = '0;
                pv_d[k]  = 1'b0;
            end
        end
        if (busy_q) begin
            if (pv_d == '0) begin
                busy_d = 1'b0;
                ack_d  = 1'b1;
            end
        end else if (div_upd_i) begin
            busy_d = 1'b1;
            pv_d   = '1;
            for (int k = 0; k < CHNL_NUM; k++) begin
                pend_d[k] = div_val_i[k*DIV_WIDTH +: DIV_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            pv_q   <= '0;
            ce_q   <= '0;
            dc_q   <= '0;
            for (int k = 0; k < CHNL_NUM; k++) begin
                sh_q[k]   <= DIV_WIDTH'(1);
                pend_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            ack_q  <= ack_d;
            pv_q   <= pv_d;
            ce_q   <= ce_d;
            dc_q   <= dc_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign div_upd_ack_o = ack_q;
    assign div_busy_o    = busy_q;
    assign pll_en_o      = (state_q != S_OFF);
    assign pll_sel_o     = run_q;
    assign state_o       = state_q;
    assign lock_lost_o   = lost_q;
    assign clk_en_o      = ce_q;
    assign div_clk_o     = dc_q;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// tb_rcu_pll_seq: scoreboard bench, reference model pushes expected outputs each edge.
// Covers the timeout path when built with RCU_PLL_TIMEOUT_EN.
module tb_rcu_pll_seq;

    localparam int CN  = 4;
    localparam int DW  = 8;
    localparam int LW  = 16;
    localparam int TMO = 20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          pll_en_i = 1'b0;
    logic [LW-1:0] lock_wait_i = '0;
    logic          pll_lock_i = 1'b0;
    logic [CN*DW-1:0] div_val_i = '0;
    logic          div_upd_i = 1'b0;
    logic          div_upd_ack_o, div_busy_o, pll_en_o, pll_sel_o;
    logic [1:0]    state_o;
    logic          lock_lost_o, timeout_o;
    logic          lock_lost_clr_i = 1'b0;
    logic [CN-1:0] clk_en_o, div_clk_o;

    rcu_pll_seq #(
        .CHNL_NUM(CN),
        .DIV_WIDTH(DW),
        .LOCK_CNT_WIDTH(LW),
        .TIMEOUT_CYC(16'd20)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pll_en_i(pll_en_i),
        .lock_wait_i(lock_wait_i),
        .pll_lock_i(pll_lock_i),
        .div_val_i(div_val_i),
        .div_upd_i(div_upd_i),
        .div_upd_ack_o(div_upd_ack_o),
        .div_busy_o(div_busy_o),
        .pll_en_o(pll_en_o),
        .pll_sel_o(pll_sel_o),
        .state_o(state_o),
        .lock_lost_o(lock_lost_o),
        .lock_lost_clr_i(lock_lost_clr_i),
        .timeout_o(timeout_o),
        .clk_en_o(clk_en_o),
        .div_clk_o(div_clk_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [15:0] exp_q[$];

    // reference model state
    int m_st, m_stab;
    bit m_lost, m_tmo;
    bit lk_hist[$];
    int d[CN], t[CN], pend[CN];
    bit pv[CN];
    bit busy, ack;
    bit [CN-1:0] ce, dc;
`ifdef RCU_PLL_TIMEOUT_EN
    int m_acq;
    bit m_blk, nblk;
`endif

    always @(posedge clk_i) begin
        bit ls, set_lost, act, alldone;
        int nst, nstab, ph;
        if (rst_i) begin
            m_st = 0; m_stab = 0; m_lost = 0; m_tmo = 0;
            busy = 0; ack = 0; ce = '0; dc = '0;
            lk_hist = {1'b0, 1'b0};
            for (int k = 0; k < CN; k++) begin
                d[k] = 1; t[k] = 0; pend[k] = 0; pv[k] = 0;
            end
`ifdef RCU_PLL_TIMEOUT_EN
            m_acq = 0; m_blk = 0;
`endif
        end else begin
            ls = lk_hist.pop_front();
            lk_hist.push_back(pll_lock_i);
            nst = m_st; nstab = 0; set_lost = 0;
`ifdef RCU_PLL_TIMEOUT_EN
            nblk = m_blk && pll_en_i;
`endif
            if (!pll_en_i) nst = 0;
            else if (m_st == 0) begin
`ifdef RCU_PLL_TIMEOUT_EN
                if (!m_blk) begin nst = 1; m_tmo = 0; end
`else
                nst = 1;
`endif
            end else if (m_st == 1) begin
                if (ls) nst = 2;
`ifdef RCU_PLL_TIMEOUT_EN
                else if (m_acq + 1 == TMO) begin
                    nst = 0; m_tmo = 1; nblk = 1;
                end
`endif
            end else if (m_st == 2) begin
                if (!ls) nst = 1;
                else if (m_stab == int'(lock_wait_i)) nst = 3;
                else nstab = m_stab + 1;
            end else begin
                if (!ls) begin nst = 1; set_lost = 1; end
            end
            if (set_lost) m_lost = 1;
            else if (lock_lost_clr_i) m_lost = 0;
`ifdef RCU_PLL_TIMEOUT_EN
            m_acq = (m_st == 1 && nst == 1) ? m_acq + 1 : 0;
            m_blk = nblk;
`endif
            act = (m_st == 3) && (nst == 3);
            for (int k = 0; k < CN; k++) begin
                ph = (d[k] <= 1) ? 0 : t[k] % d[k];
                ce[k] = act && (d[k] <= 1 || ph == d[k] - 1);
                dc[k] = act && d[k] >= 2 && ph < d[k] / 2;
                if (pv[k] && (m_st != 3 || d[k] <= 1 || ph == d[k] - 1)) begin
                    d[k] = pend[k]; t[k] = 0; pv[k] = 0;
                end else begin
                    t[k] = act ? t[k] + 1 : 0;
                end
            end
            ack = 0;
            alldone = 1;
            for (int k = 0; k < CN; k++) if (pv[k]) alldone = 0;
            if (busy) begin
                if (alldone) begin busy = 0; ack = 1; end
            end else if (div_upd_i) begin
                busy = 1;
                for (int k = 0; k < CN; k++) begin
                    pend[k] = int'(div_val_i[k*DW +: DW]);
                    pv[k] = 1;
                end
            end
            m_st = nst;
            m_stab = nstab;
        end
        exp_q.push_back({2'(m_st), m_st != 0, m_st == 3, m_lost, m_tmo,
                         busy, ack, ce, dc});
    end

    always @(posedge clk_i) begin
        logic [15:0] e, a;
        #1;
        cyc++;
        a = {state_o, pll_en_o, pll_sel_o, lock_lost_o, timeout_o,
             div_busy_o, div_upd_ack_o, clk_en_o, div_clk_o};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cyc=%0d got=%h", cyc, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic upd(input logic [CN*DW-1:0] v);
        div_val_i = v;
        div_upd_i = 1'b1;
        tick(1);
        div_upd_i = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_i = 1'b0;
        tick(2);
        pll_en_i = 1'b1;
        lock_wait_i = 16'd10;
        tick(5);
        pll_lock_i = 1'b1;
        tick(25);
        upd({8'd3, 8'd5, 8'd1, 8'd4});
        tick(40);
        upd({8'd3, 8'd5, 8'd1, 8'd6});
        tick(2);
        upd({8'd7, 8'd2, 8'd9, 8'd2});
        tick(30);
        pll_lock_i = 1'b0;
        tick(3);
        pll_lock_i = 1'b1;
        tick(30);
        lock_lost_clr_i = 1'b1;
        tick(1);
        lock_lost_clr_i = 1'b0;
        tick(5);
        pll_lock_i = 1'b0;
        tick(4);
        pll_lock_i = 1'b1;
        tick(6);
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
        tick(20);
        pll_en_i = 1'b0;
        tick(1);
        pll_en_i = 1'b1;
        tick(3);
        pll_en_i = 1'b0;
        tick(2);
        pll_en_i = 1'b1;
        tick(8);
        pll_en_i = 1'b0;
        tick(2);
        pll_en_i = 1'b1;
        tick(20);
        pll_lock_i = 1'b0;
        tick(3);
        lock_wait_i = '0;
        pll_lock_i = 1'b1;
        tick(10);
`ifdef RCU_PLL_TIMEOUT_EN
        pll_lock_i = 1'b0;
        tick(40);
        pll_en_i = 1'b0;
        tick(2);
        pll_en_i = 1'b1;
        tick(25);
        pll_en_i = 1'b0;
        tick(1);
        pll_en_i = 1'b1;
        pll_lock_i = 1'b1;
        tick(20);
`endif
        for (int i = 0; i < 4000; i++) begin
            pll_en_i = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 29) == 0) pll_lock_i = ~pll_lock_i;
            if ($urandom_range(0, 99) == 0) lock_wait_i = LW'($urandom_range(0, 6));
            div_upd_i = ($urandom_range(0, 7) == 0);
            if (div_upd_i)
                for (int c = 0; c < CN; c++)
                    div_val_i[c*DW +: DW] = DW'($urandom_range(0, 9));
            lock_lost_clr_i = ($urandom_range(0, 39) == 0);
            rst_i = ($urandom_range(0, 1999) == 0);
            tick(1);
        end
        rst_i = 1'b0;
        div_upd_i = 1'b0;
        lock_lost_clr_i = 1'b0;
        tick(2);
        @(posedge clk_i);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
